rr_burst_arbiter: RTL

- Round-robin arbiter that shares one downstream resource (bus, memory port, FIFO write side) between N requesters at burst granularity.
- The grant is held until the winner's last beat transfers, a beat cap is hit, or the winner abandons its request.
- Priority rotates to the requester after the previous winner.
- Grant is registered, matching the single-beat arbiter already in the design, so it drops into the same request/grant fabric.

---
 rtl/rr_burst_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that holds a registered grant for a whole burst.
// Releases on the last beat, a beat cap, or when the winner abandons its request.
module rr_burst_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BEATS = 16,
    parameter int IDW       = $clog2(N),
    parameter int CNTW      = $clog2(MAX_BEATS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_last,
    input  logic            res_ready,
    output logic [N-1:0]    grant,
    output logic [IDW-1:0]  grant_id,
    output logic            busy,
    output logic [CNTW-1:0] beat_cnt,
    output logic            timeout_pulse,
    output logic            abort_pulse
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic [IDW-1:0]  r_grant_id;
    logic [CNTW-1:0] r_beat_cnt;
    logic [IDW-1:0]  r_ptr;
    logic            r_timeout;
    logic            r_abort;

    logic            w_found;
    logic [IDW-1:0]  w_winner;
    logic [IDW:0]    w_sum;
    logic            w_req_g;
    logic            w_last_g;
    logic            w_xfer;
    logic            w_at_cap;
    logic [IDW-1:0]  w_next_ptr;

    // First requester at or after r_ptr, wrapping modulo N.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(N)) begin
                w_sum = w_sum - (IDW+1)'(N);
            end
            if (!w_found && req[w_sum[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDW-1:0];
            end
        end
    end

    assign w_req_g    = req[r_grant_id];
    assign w_last_g   = req_last[r_grant_id];
    assign w_xfer     = (r_state == BUSY) && w_req_g && res_ready;
    assign w_at_cap   = (r_beat_cnt == CNTW'(MAX_BEATS - 1));
    assign w_next_ptr = (r_grant_id == IDW'(N - 1)) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_ptr      <= '0;
            r_timeout  <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= BUSY;
                        r_grant    <= N'(1) << w_winner;
                        r_grant_id <= w_winner;
                        r_beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    // Abort outranks completion; a last beat on the cap beat is a normal end.
                    if (!w_req_g || (w_xfer && (w_last_g || w_at_cap))) begin
                        r_state    <= IDLE;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                        r_beat_cnt <= '0;
                        r_ptr      <= w_next_ptr;
                        r_abort    <= !w_req_g;
                        r_timeout  <= w_req_g && !w_last_g;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant         = r_grant;
    assign grant_id      = r_grant_id;
    assign busy          = |r_grant;
    assign beat_cnt      = r_beat_cnt;
    assign timeout_pulse = r_timeout;
    assign abort_pulse   = r_abort;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));
    a_cnt_bounded   : assert property (@(posedge clk) disable iff (rst)
                                       r_beat_cnt <= CNTW'(MAX_BEATS - 1));
    a_single_pulse  : assert property (@(posedge clk) disable iff (rst) !(r_timeout && r_abort));

endmodule
